alu_decode_unit: RTL and testbench

ALU_DECODE_UNIT -- requirements
Module: alu_decode_unit

---
 rtl/alu_decode_unit.sv | 106 ++++++++++
 tb/tb_alu_decode_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_decode_unit.sv
// Instruction decode, operand mux and 8-bit ALU with the W working register
// and the C/Z status flags; everything but W, C and Z is combinational.
module alu_decode_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] inst_reg,
  input  logic [7:0] f,
  input  logic [7:0] k,
  output logic [3:0] inst,
  output logic       d,
  output logic       switch_a_m,
  output logic [7:0] b,
  output logic [8:0] ans,
  output logic [7:0] w,
  output logic       carry,
  output logic       zero,
  output logic       f_we,
  output logic [7:0] f_out
);

  logic [8:0] alu_res;
  logic       we;
  logic       c_upd;
  logic       z_upd;
  logic       unused_bit0;

  assign unused_bit0 = inst_reg[0];

  // Literal opcode 1011 has no defined mapping and is treated as a NOP.
  always_comb begin
    inst       = 4'b0000;
    d          = 1'b0;
    switch_a_m = 1'b0;
    case (inst_reg[7:6])
      2'b00: begin
        inst = inst_reg[5:2];
        d    = inst_reg[1];
      end
      2'b11: begin
        switch_a_m = 1'b1;
        casez (inst_reg[5:2])
          4'b0???: inst = 4'b1000;
          4'b1000: inst = 4'b0100;
          4'b1001: inst = 4'b0101;
          4'b1010: inst = 4'b0110;
          4'b110?: inst = 4'b0010;
          4'b111?: inst = 4'b0111;
          default: inst = 4'b0000;
        endcase
      end
      default: ;
    endcase
  end

  assign b = switch_a_m ? k : f;

  always_comb begin
    alu_res = 9'd0;
    case (inst)
      4'b0000: alu_res = d ? {1'b0, w} : 9'd0;
      4'b0001: alu_res = 9'd0;
      4'b0010: alu_res = {1'b0, b} + {1'b0, ~w} + 9'd1;
      4'b0011,
      4'b1011: alu_res = {1'b0, b - 8'd1};
      4'b0100: alu_res = {1'b0, b | w};
      4'b0101: alu_res = {1'b0, b & w};
      4'b0110: alu_res = {1'b0, b ^ w};
      4'b0111: alu_res = {1'b0, b} + {1'b0, w};
      4'b1000: alu_res = {1'b0, b};
      4'b1001: alu_res = {1'b0, ~b};
      4'b1010,
      4'b1111: alu_res = {1'b0, b + 8'd1};
      4'b1100: alu_res = {b[0], carry, b[7:1]};
      4'b1101: alu_res = {b[7], b[6:0], carry};
      4'b1110: alu_res = {1'b0, b[3:0], b[7:4]};
      default: alu_res = 9'd0;
    endcase
  end

  // Only inst 0000 with d = 0 (including the decoded NOP classes) writes nothing.
  assign we    = (inst != 4'b0000) || d;
  assign c_upd = (inst == 4'b0111) || (inst == 4'b0010) ||
                 (inst == 4'b1100) || (inst == 4'b1101);
  assign z_upd = we && (inst != 4'b0000) && (inst != 4'b1100) &&
                 (inst != 4'b1101) && (inst != 4'b1110);

  assign ans   = reset ? alu_res : 9'd0;
  assign f_we  = reset && we && d;
  assign f_out = ans[7:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w     <= 8'd0;
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (we) begin
      if (!d)
        w <= alu_res[7:0];
      if (c_upd)
        carry <= alu_res[8];
      if (z_upd)
        zero <= (alu_res[7:0] == 8'd0);
    end
  end

endmodule

// File: tb/tb_alu_decode_unit.sv
// Scoreboard bench for alu_decode_unit: a stimulus process pushes expected
// per-cycle outputs from a behavioural model, a monitor pops and compares.
module tb_alu_decode_unit;

  logic       clk;
  logic       reset;
  logic [7:0] inst_reg, f, k;
  logic [3:0] inst;
  logic       d, switch_a_m, carry, zero, f_we;
  logic [7:0] b, w, f_out;
  logic [8:0] ans;

  typedef struct {
    logic [3:0] inst;
    logic       d;
    logic       swm;
    logic [7:0] b;
    logic [8:0] ans;
    logic       fwe;
    logic [7:0] fout;
    logic [7:0] w;
    logic       c;
    logic       z;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  bit   stimDone = 0;

  int mW = 0;
  int mC = 0;
  int mZ = 0;

  alu_decode_unit dut (
    .clk(clk), .reset(reset), .inst_reg(inst_reg), .f(f), .k(k),
    .inst(inst), .d(d), .switch_a_m(switch_a_m), .b(b), .ans(ans),
    .w(w), .carry(carry), .zero(zero), .f_we(f_we), .f_out(f_out)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [8:0] act, input logic [8:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: drive inputs, predict this cycle's outputs, then advance state.
  task automatic applyStimulus(input int ir, input int fv, input int kv, input bit rst);
    exp_t e;
    int cls, op, op_i, dd, sm, bb, res, we, cu, zu;
    inst_reg = ir[7:0];
    f        = fv[7:0];
    k        = kv[7:0];
    reset    = rst;
    if (!rst) begin
      mW = 0; mC = 0; mZ = 0;
    end
    cls = ir / 64;
    op  = (ir / 4) % 16;
    op_i = 0; dd = 0; sm = 0;
    if (cls == 0) begin
      op_i = op; dd = (ir / 2) % 2;
    end else if (cls == 3) begin
      sm = 1;
      if (op < 8) op_i = 8;
      else if (op >= 8 && op <= 10) op_i = op - 4;
      else if (op == 12 || op == 13) op_i = 2;
      else if (op >= 14) op_i = 7;
    end
    bb = sm ? kv : fv;
    case (op_i)
      0:      res = dd ? mW : 0;
      1:      res = 0;
      2:      res = bb - mW + 256;
      3, 11:  res = (bb + 255) % 256;
      4:      res = bb | mW;
      5:      res = bb & mW;
      6:      res = bb ^ mW;
      7:      res = bb + mW;
      8:      res = bb;
      9:      res = 255 - bb;
      10, 15: res = (bb + 1) % 256;
      12:     res = (bb / 2) + mC * 128 + (bb % 2) * 256;
      13:     res = (bb * 2 + mC) % 512;
      default: res = (bb % 16) * 16 + bb / 16;
    endcase
    we = (op_i != 0 || dd == 1) ? 1 : 0;
    cu = (op_i == 2 || op_i == 7 || op_i == 12 || op_i == 13) ? 1 : 0;
    zu = (we == 1 && !(op_i == 0 || op_i == 12 || op_i == 13 || op_i == 14)) ? 1 : 0;
    if (!rst) res = 0;
    e.inst = op_i[3:0];
    e.d    = dd[0];
    e.swm  = sm[0];
    e.b    = bb[7:0];
    e.ans  = res[8:0];
    e.fwe  = rst && we == 1 && dd == 1;
    e.fout = res[7:0];
    e.w    = mW[7:0];
    e.c    = mC[0];
    e.z    = mZ[0];
    expq.push_back(e);
    if (rst && we == 1) begin
      if (dd == 0) mW = res % 256;
      if (cu == 1) mC = res / 256;
      if (zu == 1) mZ = (res % 256 == 0) ? 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compares every expected entry at the falling edge, away from the update edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        checkOutput("inst", {5'd0, inst}, {5'd0, e.inst});
        checkOutput("d", {8'd0, d}, {8'd0, e.d});
        checkOutput("switch_a_m", {8'd0, switch_a_m}, {8'd0, e.swm});
        checkOutput("b", {1'b0, b}, {1'b0, e.b});
        checkOutput("ans", ans, e.ans);
        checkOutput("f_we", {8'd0, f_we}, {8'd0, e.fwe});
        checkOutput("f_out", {1'b0, f_out}, {1'b0, e.fout});
        checkOutput("w", {1'b0, w}, {1'b0, e.w});
        checkOutput("carry", {8'd0, carry}, {8'd0, e.c});
        checkOutput("zero", {8'd0, zero}, {8'd0, e.z});
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ir;
    reset = 0; inst_reg = 0; f = 0; k = 0;
    @(posedge clk);
    #1;
    applyStimulus(8'h1D, 10, 0, 0);
    applyStimulus(8'h1D, 10, 0, 1);
    applyStimulus(8'h1D, 10, 0, 1);
    applyStimulus(8'h09, 10, 0, 1);
    applyStimulus(8'hC0, 8'h33, 8'h5A, 1);
    applyStimulus(8'hF8, 8'h33, 8'hC8, 1);
    applyStimulus(8'h27, 8'h0F, 8'h00, 1);
    applyStimulus(8'h40, 8'hAA, 8'h55, 1);
    applyStimulus(8'h41, 8'hAA, 8'h55, 1);
    applyStimulus(8'h05, 8'h12, 8'h34, 1);
    applyStimulus(8'h05, 8'h12, 8'h34, 0);
    applyStimulus(8'hC0, 8'h00, 8'hFF, 1);
    applyStimulus(8'hFC, 8'h00, 8'h01, 1);
    applyStimulus(8'h0C, 8'h00, 8'h00, 1);
    applyStimulus(8'h0D, 8'h00, 8'h00, 1);
    applyStimulus(8'h2A, 8'hFF, 8'h00, 1);
    applyStimulus(8'h33, 8'h81, 8'h00, 1);
    applyStimulus(8'h34, 8'h81, 8'h00, 1);
    applyStimulus(8'h3B, 8'hA5, 8'h00, 1);
    applyStimulus(8'h03, 8'h00, 8'h00, 1);
    for (int i = 0; i < 400; i++) begin
      do ir = int'($urandom_range(255)); while (ir / 64 == 3 && (ir / 4) % 16 == 11);
      applyStimulus(ir, int'($urandom_range(255)), int'($urandom_range(255)),
                    $urandom_range(31) != 0);
    end
    repeat (3) @(posedge clk);
    stimDone = 1;
    checkOutput("queue_drained", 9'(expq.size()), 9'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
